node_t21_gen: RTL

NODE_T21_GEN -- requirements
Module: node_t21_gen

---
 rtl/node_pkg.sv | 40 ++++
 rtl/node_alu_sat.sv | 91 +++++++++
 rtl/node_t21_gen.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/node_pkg.sv
// Shared encodings for the node: opcodes, register selectors, jump
// conditions and the sequencer state type.
package node_pkg;

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_JRO = 4'b1010;
    localparam logic [3:0] OP_JCC = 4'b1011;
    localparam logic [3:0] OP_NEG = 4'b1100;
    localparam logic [3:0] OP_SAV = 4'b1101;
    localparam logic [3:0] OP_SWP = 4'b1110;
    localparam logic [3:0] OP_HCF = 4'b1111;

    // Register selectors; values 4..7 address ports 0..3
    localparam logic [2:0] REG_ACC  = 3'd0;
    localparam logic [2:0] REG_NIL  = 3'd1;
    localparam logic [2:0] REG_ANY  = 3'd2;
    localparam logic [2:0] REG_LAST = 3'd3;

    localparam logic [2:0] CC_JMP = 3'd0;
    localparam logic [2:0] CC_JEZ = 3'd1;
    localparam logic [2:0] CC_JNZ = 3'd2;
    localparam logic [2:0] CC_JGZ = 3'd3;
    localparam logic [2:0] CC_JLZ = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TX   = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Lowest set bit of a 4-bit port vector (3 when only bit 3 or none is set)
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        return 2'd3;
    endfunction

endpackage

// File: rtl/node_alu_sat.sv
// Source operand selection (constant, ACC, NIL, ANY, LAST, ports) and the
// saturating ADD/SUB/NEG datapath. Purely combinational.
module node_alu_sat
    import node_pkg::*;
#(
    parameter int DATA_W  = 11,
    parameter int SAT_MAX = 999
) (
    input  logic        [3:0]          op,
    input  logic                       reg_flag,
    input  logic        [DATA_W-1:0]   operand,
    input  logic signed [DATA_W-1:0]   acc,
    input  logic        [4*DATA_W-1:0] in_data,
    input  logic        [3:0]          ready,
    input  logic        [1:0]          last_port,
    input  logic                       last_valid,
    output logic signed [DATA_W-1:0]   src_val,
    output logic                       src_wait,
    output logic                       src_take,
    output logic        [1:0]          src_idx,
    output logic signed [DATA_W-1:0]   alu_res
);

    localparam logic signed [DATA_W:0] SAT_HI = (DATA_W+1)'(SAT_MAX);
    localparam logic signed [DATA_W:0] SAT_LO = -SAT_HI;

    // Clamp a one-bit-wider intermediate into [-SAT_MAX, +SAT_MAX]
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] v);
        if (v > SAT_HI)      return SAT_HI[DATA_W-1:0];
        else if (v < SAT_LO) return SAT_LO[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    logic        [2:0]        sel;
    logic signed [DATA_W-1:0] port_word [4];
    logic signed [DATA_W:0]   acc_x;
    logic signed [DATA_W:0]   src_x;

    assign sel   = operand[DATA_W-1 -: 3];
    assign acc_x = {acc[DATA_W-1], acc};
    assign src_x = {src_val[DATA_W-1], src_val};

    for (genvar k = 0; k < 4; k++) begin : g_port
        assign port_word[k] = in_data[k*DATA_W +: DATA_W];
    end

    // Resolve the source operand and whether it must wait for a neighbour
    always_comb begin
        src_val  = '0;
        src_wait = 1'b0;
        src_take = 1'b0;
        src_idx  = 2'd0;
        if (!reg_flag) begin
            src_val = sat({operand[DATA_W-1], operand});
        end else begin
            case (sel)
                REG_ACC: src_val = acc;
                REG_NIL: ;
                REG_ANY: begin
                    src_idx  = lowest_idx(ready);
                    src_take = |ready;
                    src_wait = ~|ready;
                end
                REG_LAST: begin
                    if (last_valid) begin
                        src_idx  = last_port;
                        src_take = ready[last_port];
                        src_wait = ~ready[last_port];
                    end
                end
                default: begin
                    src_idx  = sel[1:0];
                    src_take = ready[sel[1:0]];
                    src_wait = ~ready[sel[1:0]];
                end
            endcase
            if (src_take) src_val = port_word[src_idx];
        end
    end

    // Arithmetic in DATA_W+1 bits so the clamp sees the true result
    always_comb begin
        case (op)
            OP_ADD:  alu_res = sat(acc_x + src_x);
            OP_SUB:  alu_res = sat(acc_x - src_x);
            OP_NEG:  alu_res = sat(-acc_x);
            default: alu_res = acc;
        endcase
    end

endmodule

// File: rtl/node_t21_gen.sv
// Single programmable node: instruction memory, PC/ACC/BAK state and the
// RUN/TX/HALT sequencer handling port handshakes.
module node_t21_gen
    import node_pkg::*;
#(
    parameter  int DATA_W  = 11,
    parameter  int ADDR_W  = 4,
    parameter  int SAT_MAX = 999,
    localparam int INSTR_W = DATA_W + 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic        [ADDR_W-1:0]   instrAddr,
    input  logic        [INSTR_W-1:0]  instrData,
    input  logic                       writeInstr,
    input  logic        [ADDR_W-1:0]   lastAddr,
    input  logic        [4*DATA_W-1:0] inData,
    input  logic        [3:0]          ready,
    input  logic        [3:0]          done,
    output logic signed [DATA_W-1:0]   outData,
    output logic        [3:0]          send,
    output logic        [3:0]          recv,
    output logic                       halted,
    output logic        [ADDR_W-1:0]   pc
);

    logic        [INSTR_W-1:0] prog_mem [2**ADDR_W];
    logic        [INSTR_W-1:0] instr;
    logic        [3:0]         op;
    logic                      reg_flag;
    logic        [DATA_W-1:0]  operand;
    logic signed [DATA_W-1:0]  acc, bak;
    logic        [1:0]         last_port;
    logic                      last_valid;
    state_t                    state;

    logic signed [DATA_W-1:0]  src_val, alu_res;
    logic                      src_wait, src_take;
    logic        [1:0]         src_idx;

    logic                      uses_src, stall, cc_take, mov_tx;
    logic        [2:0]         dst, cond;
    logic        [3:0]         mov_mask;
    logic        [ADDR_W-1:0]  pc_seq, jump_tgt, jro_pc;
    logic signed [DATA_W+1:0]  jro_sum, last_ext;

    assign instr    = prog_mem[pc];
    assign op       = instr[INSTR_W-1 -: 4];
    assign reg_flag = instr[DATA_W];
    assign operand  = instr[DATA_W-1:0];
    assign dst      = op[2:0];
    assign cond     = operand[DATA_W-1 -: 3];
    assign halted   = (state == ST_HALT);

    node_alu_sat #(.DATA_W(DATA_W), .SAT_MAX(SAT_MAX)) u_alu (
        .op(op), .reg_flag(reg_flag), .operand(operand), .acc(acc),
        .in_data(inData), .ready(ready), .last_port(last_port),
        .last_valid(last_valid), .src_val(src_val), .src_wait(src_wait),
        .src_take(src_take), .src_idx(src_idx), .alu_res(alu_res)
    );

    assign uses_src = !op[3] || op == OP_ADD || op == OP_SUB || op == OP_JRO;
    assign stall    = uses_src && src_wait;
    assign pc_seq   = (pc == lastAddr) ? '0 : pc + ADDR_W'(1);
    assign jump_tgt = (operand[ADDR_W-1:0] > lastAddr) ? '0 : operand[ADDR_W-1:0];

    // Relative jump: signed sum in a wide domain, clamped to [0, lastAddr]
    assign jro_sum  = {{(DATA_W+2-ADDR_W){1'b0}}, pc} + {{2{src_val[DATA_W-1]}}, src_val};
    assign last_ext = {{(DATA_W+2-ADDR_W){1'b0}}, lastAddr};
    assign jro_pc   = (jro_sum < 0) ? '0 :
                      (jro_sum > last_ext) ? lastAddr : jro_sum[ADDR_W-1:0];

    // MOV destinations that go out on ports; LAST without history acts as NIL
    assign mov_tx   = dst[2] || dst == REG_ANY || (dst == REG_LAST && last_valid);
    assign mov_mask = dst[2] ? (4'b0001 << dst[1:0]) :
                      (dst == REG_ANY) ? 4'b1111 : (4'b0001 << last_port);

    // Condition evaluation for Jcc
    always_comb begin
        case (cond)
            CC_JMP:  cc_take = 1'b1;
            CC_JEZ:  cc_take = (acc == 0);
            CC_JNZ:  cc_take = (acc != 0);
            CC_JGZ:  cc_take = (acc > 0);
            CC_JLZ:  cc_take = (acc < 0);
            default: cc_take = 1'b0;
        endcase
    end

    // Program memory write port; unaffected by reset
    always_ff @(posedge clk) begin
        if (writeInstr) prog_mem[instrAddr] <= instrData;
    end

    // Sequencer: executes in RUN, holds an outgoing offer in TX, parks in HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= '0;
            acc        <= '0;
            bak        <= '0;
            outData    <= '0;
            send       <= '0;
            recv       <= '0;
            last_port  <= 2'd0;
            last_valid <= 1'b0;
            state      <= ST_RUN;
        end else begin
            recv <= '0;
            case (state)
                ST_RUN: begin
                    if (!stall) begin
                        if (uses_src && src_take) begin
                            recv       <= 4'b0001 << src_idx;
                            last_port  <= src_idx;
                            last_valid <= 1'b1;
                        end
                        if (!op[3]) begin
                            if (mov_tx) begin
                                outData <= src_val;
                                send    <= mov_mask;
                                state   <= ST_TX;
                            end else begin
                                if (dst == REG_ACC) acc <= src_val;
                                pc <= pc_seq;
                            end
                        end else begin
                            case (op)
                                OP_ADD, OP_SUB, OP_NEG: begin
                                    acc <= alu_res;
                                    pc  <= pc_seq;
                                end
                                OP_JRO: pc <= jro_pc;
                                OP_JCC: pc <= cc_take ? jump_tgt : pc_seq;
                                OP_SAV: begin
                                    bak <= acc;
                                    pc  <= pc_seq;
                                end
                                OP_SWP: begin
                                    acc <= bak;
                                    bak <= acc;
                                    pc  <= pc_seq;
                                end
                                default: state <= ST_HALT;
                            endcase
                        end
                    end
                end
                ST_TX: begin
                    if (|(send & done)) begin
                        send  <= '0;
                        pc    <= pc_seq;
                        state <= ST_RUN;
                        if (&send) begin
                            last_port  <= lowest_idx(send & done);
                            last_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
